// File: rtl/epu_pkg.sv
// epu_pkg: shared operand geometry and loader state encoding for the EPU front end.
package epu_pkg;
  localparam int SIG_WORDS = 16;
  localparam int KEY_WORDS = 8;
  localparam int MSG_WORDS = 8;
  localparam int FRAME_WORDS = 32;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {S_LOAD, S_PRESENT, S_DISCARD} loader_state_e;
endpackage

// File: rtl/epu_loader.sv
// epu_loader: assembles a 32-word frame into signature/key/message and presents it to the EPU,
// dropping malformed frames and counting them in a saturating error counter.
module epu_loader
  import epu_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WORD_W-1:0]             in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [SIG_WORDS*WORD_W-1:0]   signature,
  output logic [KEY_WORDS*WORD_W-1:0]   key,
  output logic [MSG_WORDS*WORD_W-1:0]   message,
  output logic                          epu_valid,
  input  logic                          epu_ready,
  output logic                          frame_err,
  output logic [ERR_CNT_W-1:0]          err_count
);
  loader_state_e                   r_state;
  logic [4:0]                      r_cnt;
  logic [FRAME_WORDS*WORD_W-1:0]   r_ops;
  logic                            r_frame_err;
  logic [ERR_CNT_W-1:0]            r_err_count;
  logic                            w_accept;
  logic                            w_err;
  assign in_ready  = !reset && r_state != S_PRESENT;
  assign w_accept  = in_valid && in_ready;
  // in_last is only legitimate on the final word of a frame being loaded
  assign w_err     = w_accept && in_last && (r_state == S_DISCARD || r_cnt != 5'(FRAME_WORDS - 1));
  assign signature = r_ops[0 +: SIG_WORDS*WORD_W];
  assign key       = r_ops[SIG_WORDS*WORD_W +: KEY_WORDS*WORD_W];
  assign message   = r_ops[(SIG_WORDS+KEY_WORDS)*WORD_W +: MSG_WORDS*WORD_W];
  assign epu_valid = r_state == S_PRESENT;
  assign frame_err = r_frame_err;
  assign err_count = r_err_count;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_LOAD;
      r_cnt       <= '0;
      r_ops       <= '0;
      r_frame_err <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_frame_err <= w_err;
      if (w_err && !(&r_err_count)) r_err_count <= r_err_count + 1'b1;
      case (r_state)
        S_LOAD: if (w_accept) begin
          r_ops[r_cnt*WORD_W +: WORD_W] <= in_data;
          r_cnt <= (in_last || &r_cnt) ? '0 : r_cnt + 1'b1;
          if (&r_cnt) r_state <= in_last ? S_PRESENT : S_DISCARD;
        end
        S_PRESENT: if (epu_ready) r_state <= S_LOAD;
        default: if (w_accept && in_last) r_state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_epu_loader.sv
// tb_epu_loader: randomized and directed checks of epu_loader against a frame-level reference model.
module tb_epu_loader;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          epu_ready = 1'b0;
  logic          in_ready, epu_valid, frame_err;
  logic [511:0]  signature;
  logic [255:0]  key, message;
  logic [7:0]    err_count;
  logic          in_ready2, epu_valid2, frame_err2;
  logic [511:0]  signature2;
  logic [255:0]  key2, message2;
  logic [1:0]    err_count2;
  int errors = 0;
  int checks = 0;
  logic [31:0] m_w [32];
  int m_idx, m_err, m_err2;
  bit m_disc, m_pres, m_fe;

  epu_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .signature(signature), .key(key), .message(message),
    .epu_valid(epu_valid), .epu_ready(epu_ready), .frame_err(frame_err), .err_count(err_count)
  );

  epu_loader #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready2), .signature(signature2), .key(key2), .message(message2),
    .epu_valid(epu_valid2), .epu_ready(epu_ready), .frame_err(frame_err2), .err_count(err_count2)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_w[i] = '0;
    m_idx = 0; m_err = 0; m_err2 = 0; m_disc = 0; m_pres = 0; m_fe = 0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] d, input bit l, input bit r);
    bit acc;
    acc = v && !m_pres;
    m_fe = 0;
    if (m_pres && r) m_pres = 0;
    else if (acc) begin
      if (m_disc) begin
        if (l) begin m_disc = 0; m_fe = 1; end
      end else begin
        m_w[m_idx] = d;
        if (m_idx == 31) begin
          m_idx = 0;
          if (l) m_pres = 1; else m_disc = 1;
        end else if (l) begin
          m_idx = 0; m_fe = 1;
        end else m_idx++;
      end
    end
    if (m_fe) begin
      if (m_err < 255) m_err++;
      if (m_err2 < 3) m_err2++;
    end
  endtask

  task automatic check_outs(input string tag);
    logic [511:0] es;
    logic [255:0] ek, em;
    for (int i = 0; i < 16; i++) es[32*i +: 32] = m_w[i];
    for (int i = 0; i < 8; i++) begin
      ek[32*i +: 32] = m_w[16+i];
      em[32*i +: 32] = m_w[24+i];
    end
    checks++; if (signature !== es) begin errors++; $display("FAIL %s signature got %h exp %h", tag, signature, es); end
    checks++; if (key !== ek) begin errors++; $display("FAIL %s key got %h exp %h", tag, key, ek); end
    checks++; if (message !== em) begin errors++; $display("FAIL %s message got %h exp %h", tag, message, em); end
    checks++; if (epu_valid !== m_pres) begin errors++; $display("FAIL %s epu_valid got %b exp %b", tag, epu_valid, m_pres); end
    checks++; if (frame_err !== m_fe) begin errors++; $display("FAIL %s frame_err got %b exp %b", tag, frame_err, m_fe); end
    checks++; if (err_count !== 8'(m_err)) begin errors++; $display("FAIL %s err_count got %0d exp %0d", tag, err_count, m_err); end
    checks++; if (err_count2 !== 2'(m_err2)) begin errors++; $display("FAIL %s err_count_w2 got %0d exp %0d", tag, err_count2, m_err2); end
  endtask

  task automatic cycle(input bit v, input logic [31:0] d, input bit l, input bit r, input string tag);
    in_valid = v; in_data = d; in_last = l; epu_ready = r;
    @(negedge clk);
    checks++;
    if (in_ready !== !m_pres) begin errors++; $display("FAIL %s in_ready got %b exp %b", tag, in_ready, !m_pres); end
    @(posedge clk); #1;
    model_step(v, d, l, r);
    check_outs(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 0; in_last = 0; epu_ready = 0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_outs("reset_hold");
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready got %b exp 0", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    cycle(0, '0, 0, 0, "reset_release");
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 32; i++) cycle(1, 32'(i), i == 31, 1, "basic");
    checks++; if (epu_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", epu_valid); end
    checks++; if (signature[31:0] !== 32'h0) begin errors++; $display("FAIL basic_sig0 got %h exp 0", signature[31:0]); end
    checks++; if (key[31:0] !== 32'h10) begin errors++; $display("FAIL basic_key0 got %h exp 10", key[31:0]); end
    checks++; if (message[255:224] !== 32'h1f) begin errors++; $display("FAIL basic_msg7 got %h exp 1f", message[255:224]); end
    cycle(0, '0, 0, 1, "basic_release");
    checks++; if (epu_valid !== 1'b0) begin errors++; $display("FAIL basic_back_to_load got %b exp 0", epu_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 32; i++) cycle(1, $urandom, i == 31, 1'($urandom_range(0, 1)), "bp_load");
    for (int i = 0; i < 10; i++) cycle(1, $urandom, 1'($urandom_range(0, 1)), 0, "bp_hold");
    cycle(0, '0, 0, 1, "bp_release");
    cycle(0, '0, 0, 0, "bp_after");
  endtask

  task automatic test_short_frame();
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, $urandom, i == 5, 0, "short");
    checks++; if (frame_err !== 1'b1 || err_count !== 8'd1) begin errors++; $display("FAIL short_err got fe=%b cnt=%0d exp fe=1 cnt=1", frame_err, err_count); end
    cycle(0, '0, 0, 0, "short_pulse_end");
    for (int i = 0; i < 32; i++) cycle(1, $urandom, i == 31, 0, "short_good");
    cycle(0, '0, 0, 1, "short_good_release");
  endtask

  task automatic test_long_frame();
    do_reset();
    for (int i = 0; i < 40; i++) cycle(1, $urandom, i == 39, 1, "long");
    checks++; if (frame_err !== 1'b1 || err_count !== 8'd1) begin errors++; $display("FAIL long_err got fe=%b cnt=%0d exp fe=1 cnt=1", frame_err, err_count); end
    cycle(0, '0, 0, 1, "long_after");
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 3; i++) cycle(1, $urandom, i == 2, 0, "sat");
      checks++; if (err_count2 !== exp_cnt[f]) begin errors++; $display("FAIL sat_frame%0d got %0d exp %0d", f, err_count2, exp_cnt[f]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 21; i++) cycle(1, $urandom | 32'h1, 0, 0, "mid_load");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_outs("mid_reset");
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset in_ready got %b exp 0", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) cycle(1, $urandom, i == 31, 0, "mid_next");
    cycle(0, '0, 0, 1, "mid_release");
  endtask

  task automatic test_random();
    bit v, l;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      v = $urandom_range(0, 3) != 0;
      l = (m_idx == 31 && !m_disc) ? $urandom_range(0, 3) != 0 : $urandom_range(0, 19) == 0;
      cycle(v, $urandom, l, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_short_frame();
    test_long_frame();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/epu_loader.md
EPU_LOADER -- requirements
Module: epu_loader

Interface
REQ-001 The block SHALL have parameter ERR_CNT_W, default 8, width of the saturating frame-error counter.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  32  upstream word.
REQ-006 in_valid  input  1  upstream word valid.
REQ-007 in_last  input  1  marks final word of a frame, qualified by in_valid.
REQ-008 in_ready  output  1  loader accepts a word this cycle.
REQ-009 signature  output  512  assembled signature to EPU.
REQ-010 key  output  256  assembled public key to EPU.
REQ-011 message  output  256  assembled message to EPU.
REQ-012 epu_valid  output  1  operand bundle valid to EPU.
REQ-013 epu_ready  input  1  EPU accepts the bundle.
REQ-014 frame_err  output  1  one-cycle pulse per malformed frame.
REQ-015 err_count  output  ERR_CNT_W  saturating count of malformed frames.

Function
REQ-016 A word SHALL transfer on a rising clk edge where in_valid && in_ready.
REQ-017 A well-formed frame SHALL be exactly 32 words, with in_last high on word 31 only.
REQ-018 Words 0-15 SHALL load signature[32*i+31:32*i], words 16-23 key[32*(i-16)+31:...], and words 24-31 message[32*(i-24)+31:...].
REQ-019 A 5-bit word counter SHALL hold the index of the next word and return to 0 on frame completion or error.
REQ-020 The FSM SHALL have states LOAD, PRESENT and DISCARD.
REQ-021 In LOAD: in_ready=1; epu_valid=0.
REQ-022 In LOAD, word 31 with in_last=1 SHALL go to PRESENT.
REQ-023 In LOAD, word 31 with in_last=0 SHALL go to DISCARD.
REQ-024 In LOAD, in_last=1 on word index < 31 SHALL pulse frame_err next cycle, increment err_count, reset the counter, and stay in LOAD.
REQ-025 In PRESENT: epu_valid=1; in_ready=0; signature/key/message SHALL be held stable.
REQ-026 In PRESENT, epu_valid && epu_ready SHALL return the FSM to LOAD on the next cycle.
REQ-027 epu_valid SHALL NOT drop without epu_ready.
REQ-028 In DISCARD: in_ready=1; epu_valid=0; words are dropped and operand registers left unchanged.
REQ-029 In DISCARD, in_last=1 SHALL pulse frame_err, increment err_count, and go to LOAD.
REQ-030 Latency: last word accepted at edge N SHALL give epu_valid=1 in the cycle following edge N.
REQ-031 epu_ready SHALL be ignored outside PRESENT.
REQ-032 err_count SHALL saturate at 2^ERR_CNT_W-1 and never wrap.
REQ-033 frame_err SHALL be registered and high for exactly one cycle per error.
REQ-034 Operand registers SHALL update only on accepted words in LOAD; partial frames SHALL leave stale words in the unloaded positions.

Reset
REQ-035 On reset assertion, asynchronously: FSM=LOAD, counter=0, epu_valid=0, frame_err=0, err_count=0, signature/key/message=0.
REQ-036 in_ready SHALL be 0 while reset is high and 1 from the first cycle after deassertion.
REQ-037 Reset mid-frame or during PRESENT SHALL abandon the frame with no frame_err pulse.

Structure
REQ-038 Shared package epu_pkg SHALL hold SIG_WORDS=16, KEY_WORDS=8, MSG_WORDS=8, FRAME_WORDS=32, WORD_W=32, and the loader state enum.
REQ-039 No sub-module SHALL be used; the block is a single FSM with a counter and operand registers.
REQ-040 The outputs SHALL connect directly to the EPU's signature, key, message, valid and ready ports.

Verification
REQ-041 Send 32 words 0x00000000..0x0000001F, last on word 31, epu_ready=1 -> epu_valid one cycle after last; signature[31:0]=0x0, key[31:0]=0x10, message[255:224]=0x1F; back to LOAD next cycle.
REQ-042 Complete frame with epu_ready held 0 for 10 cycles -> epu_valid and operands stable, in_ready=0 throughout; released on the cycle epu_ready=1.
REQ-043 in_last on word 5 -> frame_err one pulse, err_count=1; a following good frame is presented correctly.
REQ-044 40-word frame (last on word 39) -> DISCARD after word 31, no epu_valid, frame_err on word 39, err_count=1.
REQ-045 ERR_CNT_W=2 with 5 short frames -> err_count 1,2,3,3,3.
REQ-046 Reset asserted after word 20 -> outputs zero immediately, no frame_err; the next 32-word frame loads from word 0.
